// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
//   arb_state_e : arbiter FSM state (IDLE, BUSY_IF, BUSY_D), 2 bits
//   arb_win_e   : winner of the current pick (none, fetch, data)
//   ADDR_W/DATA_W : bus widths
//   sat_inc4()  : 4-bit saturating increment used by the streak counter
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_IF   = 2'd1,
        WIN_D    = 2'd2
    } arb_win_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : (v + 4'd1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection and streak next-value.
//   i_if_req, i_d_req : pending requests
//   i_streak          : consecutive data grants taken while a fetch waited
//   o_winner          : which requester wins this cycle
//   o_streak_next     : streak value to load if the winner is granted
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic       i_if_req,
    input  logic       i_d_req,
    input  logic [3:0] i_streak,
    output arb_win_e   o_winner,
    output logic [3:0] o_streak_next
);

    // Data wins by default; a fetch that has waited MAX_D_STREAK data grants wins.
    always_comb begin
        o_winner      = WIN_NONE;
        o_streak_next = i_streak;
        if (i_d_req && (!i_if_req || (i_streak != 4'(MAX_D_STREAK)))) begin
            o_winner      = WIN_D;
            // Only count data grants that actually made a fetch wait.
            o_streak_next = i_if_req ? sat_inc4(i_streak) : 4'd0;
        end else if (i_if_req) begin
            o_winner      = WIN_IF;
            o_streak_next = 4'd0;
        end else begin
            o_winner      = WIN_NONE;
            o_streak_next = i_streak;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between instruction fetch and
// load/store. One transaction at a time; all outputs are registered.
//   clk, reset (async, active-low)
//   if_req/if_addr -> if_gnt, if_rvalid, if_rdata        : fetch port
//   d_req/d_we/d_addr/d_wdata -> d_gnt, d_rvalid, d_rdata : data port
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready/mem_rdata : memory side
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_e        r_state, w_state_next;
    logic [3:0]        r_streak, w_streak_next, w_pick_streak;
    arb_win_e          w_winner;
    logic              r_if_gnt, w_if_gnt_next, r_d_gnt, w_d_gnt_next;
    logic              r_if_rvalid, w_if_rvalid_next, r_d_rvalid, w_d_rvalid_next;
    logic [DATA_W-1:0] r_if_rdata, w_if_rdata_next, r_d_rdata, w_d_rdata_next;
    logic              r_mem_req, w_mem_req_next, r_mem_we, w_mem_we_next;
    logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_next;

    mem_arb_pick #(.MAX_D_STREAK(MAX_D_STREAK)) u_pick (
        .i_if_req      (if_req),
        .i_d_req       (d_req),
        .i_streak      (r_streak),
        .o_winner      (w_winner),
        .o_streak_next (w_pick_streak)
    );

    // Next-state and next-output logic; requests are only looked at in IDLE.
    always_comb begin
        w_state_next     = r_state;
        w_streak_next    = r_streak;
        w_if_gnt_next    = 1'b0;
        w_d_gnt_next     = 1'b0;
        w_if_rvalid_next = 1'b0;
        w_d_rvalid_next  = 1'b0;
        w_if_rdata_next  = r_if_rdata;
        w_d_rdata_next   = r_d_rdata;
        w_mem_req_next   = r_mem_req;
        w_mem_we_next    = r_mem_we;
        w_mem_addr_next  = r_mem_addr;
        w_mem_wdata_next = r_mem_wdata;
        case (r_state)
            IDLE: begin
                case (w_winner)
                    WIN_IF: begin
                        w_state_next     = BUSY_IF;
                        w_streak_next    = w_pick_streak;
                        w_if_gnt_next    = 1'b1;
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = 1'b0;
                        w_mem_addr_next  = if_addr;
                        w_mem_wdata_next = 32'd0;
                    end
                    WIN_D: begin
                        w_state_next     = BUSY_D;
                        w_streak_next    = w_pick_streak;
                        w_d_gnt_next     = 1'b1;
                        w_mem_req_next   = 1'b1;
                        w_mem_we_next    = d_we;
                        w_mem_addr_next  = d_addr;
                        w_mem_wdata_next = d_wdata;
                    end
                    default: begin
                        w_state_next   = IDLE;
                        w_mem_req_next = 1'b0;
                    end
                endcase
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    w_state_next     = IDLE;
                    w_if_rvalid_next = 1'b1;
                    w_if_rdata_next  = mem_rdata;
                    w_mem_req_next   = 1'b0;
                    w_mem_we_next    = 1'b0;
                end else begin
                    w_state_next = BUSY_IF;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    w_state_next    = IDLE;
                    w_d_rvalid_next = 1'b1;
                    // Write completion returns zero rather than stale bus data.
                    w_d_rdata_next  = r_mem_we ? 32'd0 : mem_rdata;
                    w_mem_req_next  = 1'b0;
                    w_mem_we_next   = 1'b0;
                end else begin
                    w_state_next = BUSY_D;
                end
            end
            default: begin
                w_state_next   = IDLE;
                w_mem_req_next = 1'b0;
                w_mem_we_next  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset abandons any in-flight access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_streak    <= 4'd0;
            r_if_gnt    <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_if_rvalid <= 1'b0;
            r_d_rvalid  <= 1'b0;
            r_if_rdata  <= 32'd0;
            r_d_rdata   <= 32'd0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= 32'd0;
            r_mem_wdata <= 32'd0;
        end else begin
            r_state     <= w_state_next;
            r_streak    <= w_streak_next;
            r_if_gnt    <= w_if_gnt_next;
            r_d_gnt     <= w_d_gnt_next;
            r_if_rvalid <= w_if_rvalid_next;
            r_d_rvalid  <= w_d_rvalid_next;
            r_if_rdata  <= w_if_rdata_next;
            r_d_rdata   <= w_d_rdata_next;
            r_mem_req   <= w_mem_req_next;
            r_mem_we    <= w_mem_we_next;
            r_mem_addr  <= w_mem_addr_next;
            r_mem_wdata <= w_mem_wdata_next;
        end
    end

    assign if_gnt    = r_if_gnt;
    assign d_gnt     = r_d_gnt;
    assign if_rvalid = r_if_rvalid;
    assign d_rvalid  = r_d_rvalid;
    assign if_rdata  = r_if_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
module tb_mem_arbiter;

    localparam int MAX = 4;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } txn_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0, mem_ready = 1'b0;
    logic [31:0] if_addr = 32'd0, d_addr = 32'd0, d_wdata = 32'd0;
    logic        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_req, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int   n_checks = 0;
    int   n_err = 0;
    txn_t if_q[$];
    txn_t d_q[$];

    // Memory content model: word 0x10 holds 0x00500093, others a scrambled value.
    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        return ((a ^ 32'h10) * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    assign mem_rdata = mem_fn(mem_addr);

    mem_arbiter #(.MAX_D_STREAK(MAX)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / reference model ----------------
    bit   in_flight = 1'b0;
    bit   fl_if = 1'b0;
    int   m_streak = 0;
    txn_t cur;
    logic s_if, s_d, s_rdy;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_flight = 1'b0;
            m_streak  = 0;
            if_q.delete();
            d_q.delete();
        end else begin
            bit   exp_gi, exp_gd, rv;
            txn_t t;
            s_if  = if_req;
            s_d   = d_req;
            s_rdy = mem_ready;
            #1;
            exp_gd = !in_flight && s_d && (!s_if || (m_streak != MAX));
            exp_gi = !in_flight && s_if && !exp_gd;
            rv     = in_flight && s_rdy;
            chk("if_gnt", {31'd0, if_gnt}, {31'd0, exp_gi});
            chk("d_gnt", {31'd0, d_gnt}, {31'd0, exp_gd});
            chk("if_rvalid", {31'd0, if_rvalid}, {31'd0, rv && fl_if});
            chk("d_rvalid", {31'd0, d_rvalid}, {31'd0, rv && !fl_if});
            if (rv) begin
                in_flight = 1'b0;
                if (fl_if && if_q.size() > 0) begin
                    t = if_q.pop_front();
                    chk("if_rdata", if_rdata, t.rdata);
                end else if (!fl_if && d_q.size() > 0) begin
                    t = d_q.pop_front();
                    chk("d_rdata", d_rdata, t.rdata);
                end else begin
                    chk("rvalid_q_empty", 32'd1, 32'd0);
                end
            end
            if (exp_gi || exp_gd) begin
                in_flight = 1'b1;
                fl_if     = exp_gi;
                if (exp_gi && if_q.size() > 0) begin
                    cur = if_q[0];
                    m_streak = 0;
                end else if (exp_gd && d_q.size() > 0) begin
                    cur = d_q[0];
                    m_streak = s_if ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
                end else begin
                    chk("gnt_q_empty", 32'd1, 32'd0);
                end
            end
            chk("mem_req", {31'd0, mem_req}, {31'd0, in_flight});
            if (in_flight) begin
                chk("mem_addr", mem_addr, cur.addr);
                chk("mem_we", {31'd0, mem_we}, {31'd0, cur.we});
                if (!fl_if) chk("mem_wdata", mem_wdata, cur.wdata);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_if(input logic [31:0] a);
        txn_t t;
        t.addr = a; t.we = 1'b0; t.wdata = 32'd0; t.rdata = mem_fn(a);
        if_q.push_back(t);
        if_addr = a;
        if_req  = 1'b1;
    endtask

    task automatic issue_d(input logic we, input logic [31:0] a, input logic [31:0] wd);
        txn_t t;
        t.addr = a; t.we = we; t.wdata = wd; t.rdata = we ? 32'd0 : mem_fn(a);
        d_q.push_back(t);
        d_we    = we;
        d_addr  = a;
        d_wdata = wd;
        d_req   = 1'b1;
    endtask

    // One cycle of requester behaviour: drop on grant, maybe raise a new request.
    task automatic cyc(input int p_if, input int p_d, input int p_rdy);
        @(negedge clk);
        if (if_req && if_gnt) if_req = 1'b0;
        else if (!if_req && if_q.size() == 0 && int'($urandom_range(99)) < p_if)
            issue_if($urandom & 32'hFFFF_FFFC);
        if (d_req && d_gnt) d_req = 1'b0;
        else if (!d_req && d_q.size() == 0 && int'($urandom_range(99)) < p_d)
            issue_d(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom);
        mem_ready = (int'($urandom_range(99)) < p_rdy);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_if_gnt"}, {31'd0, if_gnt}, 32'd0);
        chk({tag, "_d_gnt"}, {31'd0, d_gnt}, 32'd0);
        chk({tag, "_if_rvalid"}, {31'd0, if_rvalid}, 32'd0);
        chk({tag, "_d_rvalid"}, {31'd0, d_rvalid}, 32'd0);
        chk({tag, "_if_rdata"}, if_rdata, 32'd0);
        chk({tag, "_d_rdata"}, d_rdata, 32'd0);
        chk({tag, "_mem_req"}, {31'd0, mem_req}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    endtask

    task automatic reset_pulse();
        #2;
        reset  = 1'b0;
        if_req = 1'b0;
        d_req  = 1'b0;
        #1;
        check_zero("rst");
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 40; i++) cyc(0, 0, 100);
        chk({tag, "_if_q"}, if_q.size(), 32'd0);
        chk({tag, "_d_q"}, d_q.size(), 32'd0);
    endtask

    initial begin
        int    busy;
        string seq;
        repeat (2) @(negedge clk);
        check_zero("por");
        reset = 1'b1;

        // Single fetch with zero wait states.
        cyc(0, 0, 1);
        issue_if(32'h10);
        mem_ready = 1'b1;
        cyc(0, 0, 100);
        chk("fetch_gnt_lat", {31'd0, if_gnt}, 32'd1);
        cyc(0, 0, 100);
        chk("fetch_rvalid_lat", {31'd0, if_rvalid}, 32'd1);
        chk("fetch_rdata", if_rdata, 32'h00500093);
        drain("fetch");

        // Write with three wait cycles; mem_ready is high while idle beforehand.
        cyc(0, 0, 100);
        issue_d(1'b1, 32'h64, 32'h7);
        busy = 0;
        for (int i = 0; i < 3; i++) begin cyc(0, 0, 0); busy += int'(mem_req); end
        for (int i = 0; i < 5; i++) begin cyc(0, 0, 100); busy += int'(mem_req); end
        chk("write_busy_cycles", busy, 32'd4);
        chk("write_d_rdata", d_rdata, 32'd0);
        drain("write");

        // Data requests toggling while a fetch is waiting on memory.
        cyc(0, 0, 0);
        issue_if(32'h2000);
        cyc(0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0);
            d_req  = 1'($urandom);
            d_addr = $urandom;
        end
        cyc(0, 0, 0);
        issue_d(1'b0, 32'h3000, 32'h55);
        drain("busy_toggle");

        // Reset in the middle of a data read.
        cyc(0, 0, 0);
        issue_d(1'b0, 32'h200, 32'h0);
        cyc(0, 0, 0);
        cyc(0, 0, 0);
        reset_pulse();
        for (int i = 0; i < 3; i++) cyc(0, 0, 100);
        cyc(0, 0, 100);
        issue_if(32'h40);
        drain("post_reset");

        // Both ports saturated: fetch must win every fifth grant.
        reset_pulse();
        seq = "";
        for (int i = 0; i < 60; i++) begin
            cyc(100, 100, 100);
            if (d_gnt) seq = {seq, "D"};
            if (if_gnt) seq = {seq, "I"};
        end
        n_checks++;
        if (seq.len() < 10 || seq.substr(0, 9) != "DDDDIDDDDI") begin
            n_err++;
            $display("FAIL grant_order: got %s expected DDDDIDDDDI", seq);
        end
        drain("streak");

        // Randomized traffic with wait states.
        for (int i = 0; i < 3000; i++) cyc(30, 40, 70);
        drain("random");
        for (int i = 0; i < 1500; i++) cyc(90, 90, 50);
        drain("random_heavy");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port unified memory between the processor's instruction-fetch port and its load/store port, for the multicycle core. Accepts one transaction at a time, latches its address and data, and drives the memory until `mem_ready`. It then returns read data or write completion to the winning requester. Data accesses have priority; a streak counter guarantees fetch progress.

## Interface
- `MAX_D_STREAK`, default 4: the maximum number of consecutive data grants while a fetch is pending. Legal range is 1–15.
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: asynchronous reset, active-low. Asserting it immediately forces every register to its reset value.
- `if_req` in 1: fetch request. Held until `if_gnt`.
- `if_addr` in 32: fetch byte address. Stable while `if_req` is high.
- `if_gnt` out 1: one-cycle pulse; the fetch request was accepted.
- `if_rvalid` out 1: one-cycle pulse; `if_rdata` is valid.
- `if_rdata` out 32: instruction word.
- `d_req` in 1: data request. Held until `d_gnt`.
- `d_we` in 1: 1 means write, 0 means read.
- `d_addr` in 32: data byte address.
- `d_wdata` in 32: write data.
- `d_gnt` out 1: one-cycle pulse; the data request was accepted.
- `d_rvalid` out 1: one-cycle pulse; read data is valid, or the write has completed.
- `d_rdata` out 32: load data. Holds 0 on write completion.
- `mem_req` out 1: memory access active.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: latched address.
- `mem_wdata` out 32: latched write data.
- `mem_ready` in 1: memory has completed the access this cycle. `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32: memory read data.

## Operation
- FSM states:
  - IDLE: waiting for a request.
  - BUSY_IF: fetch in flight.
  - BUSY_D: data access in flight.
- IDLE with no request: stay in IDLE.
- IDLE with a request: pick a winner, latch its address, we and wdata into the `mem_*` registers, and go to BUSY_IF or BUSY_D.
- Pick rule:
  - Only one request pending: it wins.
  - Both pending: data wins unless `streak == MAX_D_STREAK`, in which case fetch wins.
- `streak` is a 4-bit counter, reset to 0, updated only on a grant:
  - Data grant while `if_req` is high: saturating increment.
  - Fetch grant: clear to 0.
  - Data grant while `if_req` is low: clear to 0.
- `x_gnt` is high for the first cycle spent in BUSY_x. The requester deasserts or changes `x_req` at the next edge. The arbiter ignores all requests while in a BUSY state.
- `mem_req` is high throughout both BUSY states. `mem_we` is always 0 in BUSY_IF.
- A BUSY state with `mem_ready` high:
  - Capture `mem_rdata` into `x_rdata` (0 for a write).
  - Pulse `x_rvalid` in the next cycle.
  - Return to IDLE.
- `if_rdata` and `d_rdata` hold their last value between transactions.
- Reset mid-transaction: the in-flight access is abandoned and `mem_req` drops immediately. The memory must tolerate an unfinished access. No `rvalid` is produced for the abandoned access.

## Timing
- Reset values: all outputs 0, state IDLE, `streak` 0.
- All outputs are registered; none depends combinationally on any input.
- Request sampled in IDLE at edge E:
  - `x_gnt` and `mem_req` are high in the cycle after E.
  - If `mem_ready` is high in that cycle, `x_rvalid` is high in the cycle after that.
  - Minimum cost is 2 cycles per transaction.
  - Each cycle of `mem_ready` low adds 1 cycle.
- A request still high when `x_rvalid` arrives, i.e. back in IDLE, is treated as a new request.
- `mem_ready` while in IDLE is ignored.
- `if_rvalid` and `d_rvalid` are never high in the same cycle. Likewise `if_gnt` and `d_gnt`.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the state enum (IDLE, BUSY_IF, BUSY_D), 2 bits;
  - the `ADDR_W`/`DATA_W` = 32 constants.
- One sub-module, `mem_arb_pick`: combinational winner selection plus the streak next-value logic. Inputs are `if_req`, `d_req` and `streak`; outputs are the winner and `streak_next`.

## Test plan
- Single fetch:
  - Stimulus: `if_req` at 0x10, `mem_ready` high on its first cycle, `mem_rdata`=0x00500093.
  - Response: `if_gnt` 1 cycle after the request, `if_rvalid` with `if_rdata`=0x00500093 2 cycles after.
- Simultaneous requests with `MAX_D_STREAK`=4:
  - Stimulus: `if_req` and `d_req` held continuously, `mem_ready` always high.
  - Response: grant order D, D, D, D, IF, D, D, D, D, IF.
- Data write with 3 wait cycles:
  - Stimulus: `d_we`=1, address 0x64, data 0x7; `mem_ready` low for 3 cycles.
  - Response: `mem_we`=1, `mem_addr`=0x64 and `mem_wdata`=0x7 held for 4 cycles; `d_rvalid` with `d_rdata`=0 one cycle after `mem_ready`.
- Requests during BUSY:
  - Stimulus: toggle `d_req` and change `d_addr` while BUSY_IF waits on `mem_ready`.
  - Response: `mem_addr` stays unchanged; `d_gnt` occurs only after the return to IDLE.
- Reset mid-operation:
  - Stimulus: pull `reset` low while in BUSY_D.
  - Response: `mem_req` and all outputs go to 0 asynchronously; no `d_rvalid`; after release, a fresh `if_req` is granted normally with `streak` 0.
